// File: rtl/multi_debounce.sv
// multi_debounce: N-channel input conditioner for raw pedal/switch pins.
// Per channel: 2-flop sync, saturating stability filter, rise/fall pulses,
// rise-to-rise period measurement with saturation.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   raw_in   - [NUM_CH] asynchronous raw inputs, bit i = channel i
//   filt     - [NUM_CH] debounced level
//   rise     - [NUM_CH] 1-clk pulse on filt 0->1
//   fall     - [NUM_CH] 1-clk pulse on filt 1->0
//   period   - [NUM_CH*PER_W] last rise-to-rise period, ch i at [i*PER_W +: PER_W]
//   per_vld  - [NUM_CH] 1-clk pulse when period of that channel updates
module multi_debounce #(
    parameter int NUM_CH   = 1,
    parameter int FAST_SIM = 1,
    parameter int STBL_CNT = 65535,
    parameter int FAST_CNT = 511,
    parameter int CNT_W    = 16,
    parameter int PER_W    = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       raw_in,
    output logic [NUM_CH-1:0]       filt,
    output logic [NUM_CH-1:0]       rise,
    output logic [NUM_CH-1:0]       fall,
    output logic [NUM_CH*PER_W-1:0] period,
    output logic [NUM_CH-1:0]       per_vld
);

    localparam int               THRESH = (FAST_SIM != 0) ? FAST_CNT : STBL_CNT;
    localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);
    localparam logic [PER_W-1:0] PC_MAX = '1;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             s1_q, s2_q, s3_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             filt_q, filt_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic [PER_W-1:0] pc_q, pc_d;
        logic [PER_W-1:0] per_q, per_d;
        logic             vld_q, vld_d;
        logic             armed_q, armed_d;
        logic             stable;

        assign stable = (s2_q == s3_q);

        always_comb begin
            cnt_d   = cnt_q;
            filt_d  = filt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            pc_d    = pc_q;
            per_d   = per_q;
            vld_d   = 1'b0;
            armed_d = armed_q;

            if (!stable) begin
                cnt_d = '0;
            end else if (cnt_q != THR) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // A saturated counter only reflects the old level until the
            // new s2 value has propagated into s3; requiring s2 == s3 keeps
            // a fresh edge from being accepted on a stale saturated count.
            if (stable && (cnt_q == THR) && (s2_q != filt_q)) begin
                filt_d = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end

            if (pc_q != PC_MAX) begin
                pc_d = pc_q + PER_W'(1);
            end

            // The first rise after reset only arms; it has no reference edge.
            if (rise_d) begin
                pc_d    = PER_W'(1);
                armed_d = 1'b1;
                if (armed_q) begin
                    per_d = pc_q;
                    vld_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                s3_q    <= 1'b0;
                cnt_q   <= '0;
                filt_q  <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                pc_q    <= '0;
                per_q   <= '0;
                vld_q   <= 1'b0;
                armed_q <= 1'b0;
            end else begin
                s1_q    <= raw_in[g];
                s2_q    <= s1_q;
                s3_q    <= s2_q;
                cnt_q   <= cnt_d;
                filt_q  <= filt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                pc_q    <= pc_d;
                per_q   <= per_d;
                vld_q   <= vld_d;
                armed_q <= armed_d;
            end
        end

        assign filt[g]                 = filt_q;
        assign rise[g]                 = rise_q;
        assign fall[g]                 = fall_q;
        assign per_vld[g]              = vld_q;
        assign period[g*PER_W +: PER_W] = per_q;
    end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: directed bench for multi_debounce
// (2 channels, threshold 15, 12-bit period).
module tb_multi_debounce;

    localparam int NCH = 2;
    localparam int PW  = 12;

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  raw_in;
    logic [NCH-1:0]  filt, rise, fall, per_vld;
    logic [NCH*PW-1:0] period;

    multi_debounce #(
        .NUM_CH  (NCH),
        .FAST_SIM(1),
        .STBL_CNT(65535),
        .FAST_CNT(15),
        .CNT_W   (16),
        .PER_W   (PW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_in (raw_in),
        .filt   (filt),
        .rise   (rise),
        .fall   (fall),
        .period (period),
        .per_vld(per_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // pulse monitor, sampled on the falling edge
    int rc0 = 0, fc0 = 0, vc0 = 0;
    int rc1 = 0, fc1 = 0, vc1 = 0;
    int orphan = 0;
    int both   = 0;
    int per0_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rise[0]) rc0++;
            if (fall[0]) fc0++;
            if (rise[1]) rc1++;
            if (fall[1]) fc1++;
            if (per_vld[0]) begin
                vc0++;
                per0_q.push_back(int'(period[PW-1:0]));
            end
            if (per_vld[1]) vc1++;
            if ((per_vld & ~rise) != '0) orphan++;
            if ((rise & fall) != '0) both++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_filt"}, int'(filt), 0);
        chk({nm, "_rise"}, int'(rise), 0);
        chk({nm, "_fall"}, int'(fall), 0);
        chk({nm, "_vld"},  int'(per_vld), 0);
        chk({nm, "_per"},  int'(period), 0);
    endtask

    typedef struct {
        logic [1:0] mask;
        int len;
        int r0, f0, v0;
        int r1, f1, v1;
        int p0, p1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int s_r0, s_f0, s_v0, s_r1, s_f1, s_v1, qn;

        // pulse width / expected pulse counts / expected period (-1 = skip)
        tbl[0] = '{2'b01, 10, 0, 0, 0, 0, 0, 0, -1, -1};
        tbl[1] = '{2'b01, 16, 0, 0, 0, 0, 0, 0, -1, -1};
        tbl[2] = '{2'b01, 17, 1, 1, 1, 0, 0, 0, -1, -1};
        tbl[3] = '{2'b10, 17, 0, 0, 0, 1, 1, 0, -1, -1};
        tbl[4] = '{2'b11, 30, 1, 1, 1, 1, 1, 1, 114, 57};
        tbl[5] = '{2'b10,  5, 0, 0, 0, 0, 0, 0, -1, -1};

        rst_n  = 1'b0;
        raw_in = '0;
        repeat (3) step();
        chk_idle("in_reset");
        rst_n = 1'b1;

        // idle after reset
        for (int i = 0; i < 100; i++) begin
            step();
            chk_idle("idle");
        end

        // clean step on ch0: filt at edge 18
        raw_in = 2'b01;
        for (int k = 0; k < 18; k++) step();
        chk("step_filt_e17", int'(filt), 0);
        step();
        chk("step_filt_e18", int'(filt), 1);
        chk("step_rise_e18", int'(rise), 1);
        chk("step_vld_e18", int'(per_vld), 0);
        step();
        chk("step_rise_e19", int'(rise), 0);
        chk("step_filt_e19", int'(filt), 1);
        repeat (5) step();
        chk("step_rc0", rc0, 1);
        chk("step_vc0", vc0, 0);
        chk("step_per", int'(period), 0);
        raw_in = 2'b00;
        repeat (40) step();
        chk("step_fall", fc0, 1);
        chk("step_back0", int'(filt), 0);

        // glitch / pulse table
        for (int r = 0; r < 6; r++) begin
            s_r0 = rc0; s_f0 = fc0; s_v0 = vc0;
            s_r1 = rc1; s_f1 = fc1; s_v1 = vc1;
            raw_in = tbl[r].mask;
            repeat (tbl[r].len) step();
            raw_in = 2'b00;
            repeat (40) step();
            chk($sformatf("t%0d_r0", r), rc0 - s_r0, tbl[r].r0);
            chk($sformatf("t%0d_f0", r), fc0 - s_f0, tbl[r].f0);
            chk($sformatf("t%0d_v0", r), vc0 - s_v0, tbl[r].v0);
            chk($sformatf("t%0d_r1", r), rc1 - s_r1, tbl[r].r1);
            chk($sformatf("t%0d_f1", r), fc1 - s_f1, tbl[r].f1);
            chk($sformatf("t%0d_v1", r), vc1 - s_v1, tbl[r].v1);
            chk($sformatf("t%0d_filt", r), int'(filt), 0);
            if (tbl[r].p0 >= 0)
                chk($sformatf("t%0d_p0", r), int'(period[PW-1:0]), tbl[r].p0);
            if (tbl[r].p1 >= 0)
                chk($sformatf("t%0d_p1", r), int'(period[2*PW-1:PW]), tbl[r].p1);
        end

        // square wave on ch0, 200-clk period
        s_r0 = rc0; s_v0 = vc0; s_r1 = rc1;
        qn = per0_q.size();
        for (int p = 0; p < 5; p++) begin
            raw_in = 2'b01;
            repeat (100) step();
            raw_in = 2'b00;
            repeat (100) step();
        end
        chk("sq_rises", rc0 - s_r0, 5);
        chk("sq_vlds", vc0 - s_v0, 5);
        chk("sq_qlen", per0_q.size() - qn, 5);
        for (int j = 1; j < 5; j++)
            chk($sformatf("sq_per%0d", j), per0_q[qn + j], 200);
        chk("sq_per_out", int'(period[PW-1:0]), 200);
        chk("sq_ch1_rise", rc1 - s_r1, 0);
        chk("sq_ch1_per", int'(period[2*PW-1:PW]), 57);
        chk("sq_filt", int'(filt), 0);

        // slow input: 6000-clk period saturates
        s_v0 = vc0;
        raw_in = 2'b01;
        repeat (3000) step();
        raw_in = 2'b00;
        repeat (3000) step();
        raw_in = 2'b01;
        repeat (3000) step();
        raw_in = 2'b00;
        repeat (100) step();
        chk("sat_vlds", vc0 - s_v0, 2);
        chk("sat_first", per0_q[per0_q.size() - 2], 200);
        chk("sat_last", per0_q[per0_q.size() - 1], 4095);
        chk("sat_out", int'(period[PW-1:0]), 4095);

        // both channels step together
        raw_in = 2'b11;
        for (int k = 0; k < 18; k++) step();
        chk("dual_filt_e17", int'(filt), 0);
        step();
        chk("dual_filt_e18", int'(filt), 3);
        chk("dual_rise_e18", int'(rise), 3);
        repeat (5) step();

        // reset mid-count while filt is high
        raw_in = 2'b00;
        repeat (10) step();
        chk("pre_rst_filt", int'(filt), 3);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        step();
        chk_idle("mid_rst2");
        rst_n  = 1'b1;
        raw_in = 2'b11;
        for (int k = 0; k < 18; k++) step();
        chk("rst_filt_e17", int'(filt), 0);
        step();
        chk("rst_filt_e18", int'(filt), 3);
        chk("rst_rise_e18", int'(rise), 3);
        chk("rst_vld_e18", int'(per_vld), 0);
        chk("rst_per", int'(period), 0);
        step();
        chk("rst_rise_e19", int'(rise), 0);

        chk("never_both", both, 0);
        chk("no_orphan_vld", orphan, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
